// File: rtl/pb_pkg.sv
// pb_pkg: shared push-button types and default timing constants
package pb_pkg;
  typedef enum logic [1:0] {WAIT_REL, IDLE, PRESSED, LONG} pb_state_t;
  localparam int PB_LONG_CYC = 50;
  localparam int PB_REP_CYC  = 10;
endpackage

// File: rtl/pb_hold_timer.sv
// pb_hold_timer: hold counter with clear/enable and terminal-count compare against a runtime limit
// Ports: clk, rst_n (async, active-low), clr, en, limit[CNT_W-1:0] -> tc (cnt == limit)
module pb_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == limit;
endmodule

// File: rtl/pb_event_decoder.sv
// pb_event_decoder: turns the debounced button level into press/release/long-press/repeat pulses
// Ports: clk, rst_n (async, active-low), pb_db (1 = pressed) ->
//   press, released (release pulse; 'release' is a reserved word), long_press, rpt (one-cycle pulses),
//   held (level while PRESSED or LONG). All outputs registered.
// Build option: define PB_REPEAT_EN to enable auto-repeat (rpt); otherwise rpt stays 0.
module pb_event_decoder
  import pb_pkg::*;
#(
  parameter int LONG_CYC = PB_LONG_CYC,
  parameter int REP_CYC  = PB_REP_CYC,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_db,
  output logic press,
  output logic released,
  output logic long_press,
  output logic rpt,
  output logic held
);
  pb_state_t        state, state_nx;
  logic             press_nx, rel_nx, long_nx, rpt_nx, clr, en, tc;
  logic [CNT_W-1:0] limit;
  assign limit = state == LONG ? CNT_W'(REP_CYC - 1) : CNT_W'(LONG_CYC - 1);
  pb_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .limit(limit),
    .tc   (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= WAIT_REL;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_nx;
      press      <= press_nx;
      released   <= rel_nx;
      long_press <= long_nx;
      rpt        <= rpt_nx;
      held       <= state_nx == PRESSED || state_nx == LONG;
    end
  // Release is tested first in PRESSED/LONG so it wins over long_press and rpt.
  always_comb begin
    state_nx = state;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    long_nx  = 1'b0;
    rpt_nx   = 1'b0;
    clr      = 1'b0;
    en       = 1'b0;
    case (state)
      WAIT_REL: state_nx = pb_db ? WAIT_REL : IDLE;
      IDLE: if (pb_db) begin
        state_nx = PRESSED;
        press_nx = 1'b1;
        clr      = 1'b1;
      end
      PRESSED:
        if (!pb_db) begin
          state_nx = IDLE;
          rel_nx   = 1'b1;
        end else if (tc) begin
          state_nx = LONG;
          long_nx  = 1'b1;
          clr      = 1'b1;
        end else en = 1'b1;
      LONG:
        if (!pb_db) begin
          state_nx = IDLE;
          rel_nx   = 1'b1;
        end else begin
`ifdef PB_REPEAT_EN
          rpt_nx = tc;
          clr    = tc;
          en     = !tc;
`endif
        end
      default: state_nx = WAIT_REL;
    endcase
  end
endmodule

// File: doc/pb_event_decoder.md
# pb_event_decoder

Converts the debounced push-button level into single-cycle event pulses: press, release, long-press, and optional auto-repeat while held. It sits directly downstream of the push-button debouncer, in the same clock domain. It feeds game-control logic, which must never act on raw levels.

## Interface
- `LONG_CYC`, default 50: cycles a press must be held before `long_press` fires; valid range 2..2^CNT_W.
- `REP_CYC`, default 10: cycles between `rpt` pulses once long-press is reached; valid range 2..2^CNT_W.
- `CNT_W`, default 8: width of the internal hold counter.
- `clk`, input, 1: clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `pb_db`, input, 1: debounced button level from the debouncer; 1 = pressed.
- `press`, output, 1: one-cycle pulse on accepted press.
- `release`, output, 1: one-cycle pulse on release.
- `long_press`, output, 1: one-cycle pulse when hold reaches `LONG_CYC`.
- `rpt`, output, 1: one-cycle pulse every `REP_CYC` cycles after `long_press`.
- `held`, output, 1: level; 1 while state is PRESSED or LONG.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces state WAIT_REL and cnt to 0.
- FSM states, evaluated on each rising `clk` edge using the `pb_db` value sampled at that edge:
  - WAIT_REL:
    - `pb_db`=0 -> IDLE.
    - Otherwise stay. No pulses.
    - Purpose: a button already held through reset never produces `press`.
  - IDLE:
    - `pb_db`=1 -> PRESSED; `press`<=1; cnt<=0.
  - PRESSED:
    - `pb_db`=0 -> IDLE; `release`<=1.
    - Else if cnt==LONG_CYC-1 -> LONG; `long_press`<=1; cnt<=0.
    - Else cnt<=cnt+1.
  - LONG:
    - `pb_db`=0 -> IDLE; `release`<=1.
    - Else if cnt==REP_CYC-1 -> `rpt`<=1; cnt<=0.
    - Else cnt<=cnt+1.
- Pulse outputs are 0 in every cycle not listed above.
- Priority: release beats long_press and rpt in the same cycle. Only one of `press`, `release`, `long_press`, `rpt` is ever high in a cycle.
- cnt saturation never occurs, because of the parameter range limits above. The counter never wraps.
- Reset asserted mid-press: all outputs go to 0 immediately (asynchronously). After reset deasserts, the FSM sits in WAIT_REL until `pb_db` reads 0.

## Timing
- Let t0 be the edge at which IDLE samples `pb_db`=1. `press` and `held` are high in the cycle after t0.
- `long_press` is high in the cycle after edge t0+LONG_CYC, provided `pb_db` stays 1 through that edge.
- First `rpt` follows edge t0+LONG_CYC+REP_CYC. Subsequent `rpt` pulses follow every REP_CYC edges.
- Let t1 be the first edge sampling `pb_db`=0 while in PRESSED or LONG. `release` is high in the cycle after t1, and `held` drops in that same cycle.
- A re-press at edge t1+1 is accepted: `press` follows edge t1+1.

## Configuration
- `PB_REPEAT_EN` defined: LONG-state counting and `rpt` generation as specified above.
- `PB_REPEAT_EN` undefined:
  - `rpt` is tied to 0.
  - In LONG, cnt holds at 0 and the FSM only waits for release.
  - `REP_CYC` is ignored.

## Structure
- Shared package `pb_pkg` holds:
  - the state enum {WAIT_REL, IDLE, PRESSED, LONG};
  - the default `LONG_CYC` and `REP_CYC` constants shared with other button consumers.
- One sub-module, `pb_hold_timer`: a CNT_W counter with clear, enable and a terminal-count compare against a runtime limit. The FSM selects the limit: LONG_CYC-1 in PRESSED, REP_CYC-1 in LONG.

## Test plan
All scenarios use LONG_CYC=8 and REP_CYC=4.
- Reset released with `pb_db`=1 held for 20 cycles -> no pulses and `held`=0. Then `pb_db`=0 followed by 1 -> `press` appears exactly once.
- `pb_db` high for 3 cycles -> `press` after t0, `release` after edge t0+3. No `long_press`.
- `pb_db` high for 17 cycles (`PB_REPEAT_EN` on) -> `long_press` after t0+8, `rpt` after t0+12 and t0+16, `release` after t0+17.
- Same stimulus with `PB_REPEAT_EN` off -> `long_press` after t0+8, `rpt` never asserts.
- `pb_db` falls exactly at edge t0+8 -> `release` fires and `long_press` does not. Likewise a fall at t0+12 -> `release` only, no `rpt`.
- `rst_n` pulsed low at t0+5 while pressed -> all outputs 0 immediately. No `press` is seen until `pb_db` has gone 0 then 1.
